// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the instruction sequence checker.
package seq_chk_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET_CORE,
    S_ISSUE,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] expected;
    logic            check;
  } entry_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store: DEPTH entries, synchronous write, asynchronous read.
module seq_prog_mem
  import seq_chk_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  entry_t            wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output entry_t            rdata_o
);

  // Contents survive reset on purpose; prog_len alone defines validity.
  entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_seq_checker.sv
// Loads a program of {instr, expected, check}, resets the core, issues one entry
// per slot and counts matching/mismatching core results.
module instr_seq_checker
  import seq_chk_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned GAP     = 2,
  parameter int unsigned RST_CYC = 2,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [XLEN-1:0]   load_instr,
  input  logic [XLEN-1:0]   load_expect,
  input  logic              load_check,
  input  logic              clear,
  input  logic              start,
  output logic              core_nrst,
  output logic [XLEN-1:0]   core_instr,
  input  logic [XLEN-1:0]   core_result,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic [ADDR_W:0]   pass_cnt,
  output logic [ADDR_W:0]   fail_cnt,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_idx
);

  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned SLOT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int unsigned RST_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  prog_len_q, prog_len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]  pass_q, pass_d;
  logic [CNT_W-1:0]  fail_q, fail_d;
  logic              ff_valid_q, ff_valid_d;
  logic [ADDR_W-1:0] ff_idx_q, ff_idx_d;

  logic   idle_or_done_c;
  logic   load_ready_c;
  logic   load_fire_c;
  logic   slot_end_c;
  logic   last_entry_c;
  logic   match_c;
  entry_t wr_entry;
  entry_t rd_entry;

  assign idle_or_done_c = (state_q == S_IDLE) || (state_q == S_DONE);
  assign load_ready_c   = idle_or_done_c && (prog_len_q < CNT_W'(DEPTH)) && !start && !clear;
  assign load_fire_c    = load_valid && load_ready_c;
  assign slot_end_c     = (slot_q == SLOT_W'(GAP));
  assign last_entry_c   = ((CNT_W'(idx_q) + CNT_W'(1)) == prog_len_q);
  assign match_c        = (core_result == rd_entry.expected);

  assign wr_entry.instr    = load_instr;
  assign wr_entry.expected = load_expect;
  assign wr_entry.check    = load_check;

  seq_prog_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (load_fire_c),
    .waddr_i (prog_len_q[ADDR_W-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (idx_q),
    .rdata_o (rd_entry)
  );

  // Next-state: loading, run control, slot sequencing and statistics.
  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    rst_cnt_d  = rst_cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ff_valid_d = ff_valid_q;
    ff_idx_d   = ff_idx_q;

    if (load_fire_c) begin
      prog_len_d = prog_len_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (clear) begin
          prog_len_d = '0;
          pass_d     = '0;
          fail_d     = '0;
          ff_valid_d = 1'b0;
          ff_idx_d   = '0;
          state_d    = S_IDLE;
        end else if (start) begin
          pass_d     = '0;
          fail_d     = '0;
          ff_valid_d = 1'b0;
          ff_idx_d   = '0;
          rst_cnt_d  = '0;
          state_d    = S_RESET_CORE;
        end
      end
      S_RESET_CORE: begin
        if (rst_cnt_q == RST_W'(RST_CYC - 1)) begin
          idx_d   = '0;
          slot_d  = '0;
          state_d = (prog_len_q == '0) ? S_DONE : S_ISSUE;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_ISSUE: begin
        if (slot_end_c) begin
          // Result is judged on the last cycle of the slot, after the core settles.
          if (rd_entry.check) begin
            if (match_c) begin
              pass_d = pass_q + CNT_W'(1);
            end else begin
              fail_d = fail_q + CNT_W'(1);
              if (!ff_valid_q) begin
                ff_valid_d = 1'b1;
                ff_idx_d   = idx_q;
              end
            end
          end
          if (last_entry_c) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_q + ADDR_W'(1);
            slot_d = '0;
          end
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prog_len_q <= '0;
      idx_q      <= '0;
      slot_q     <= '0;
      rst_cnt_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      prog_len_q <= prog_len_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      rst_cnt_q  <= rst_cnt_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
    end
  end

  assign load_ready       = load_ready_c;
  assign busy             = (state_q == S_RESET_CORE) || (state_q == S_ISSUE);
  assign done             = (state_q == S_DONE);
  assign core_nrst        = (state_q != S_RESET_CORE);
  assign core_instr       = (state_q == S_ISSUE) ? rd_entry.instr : RV_NOP;
  assign prog_len         = prog_len_q;
  assign pass_cnt         = pass_q;
  assign fail_cnt         = fail_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;

endmodule

// File: tb/tb_instr_seq_checker.sv
// Bench for instr_seq_checker: table-driven runs plus hand-written corner sequences,
// with a per-cycle scoreboard of core_nrst/core_instr.
module tb_instr_seq_checker;
  import seq_chk_pkg::*;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned GAP     = 2;
  localparam int unsigned RST_CYC = 2;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned SLOT    = GAP + 1;

  logic              clk = 1'b0;
  logic              rst, load_valid, load_ready, load_check, clear, start;
  logic [31:0]       load_instr, load_expect, core_instr, core_result;
  logic              core_nrst, busy, done, first_fail_valid;
  logic [ADDR_W:0]   prog_len, pass_cnt, fail_cnt;
  logic [ADDR_W-1:0] first_fail_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        nrst;
    logic [31:0] instr;
  } obs_t;

  typedef struct packed {
    logic [2:0][31:0] instr;
    logic [2:0][31:0] expv;
    logic [2:0]       chk;
    logic [7:0]       exp_pass;
    logic [7:0]       exp_fail;
    logic             exp_ffv;
    logic [7:0]       exp_ffi;
  } vec_t;

  obs_t        sb[$];
  logic [31:0] prog_q[$];
  vec_t        vecs[4];

  always #5 clk = ~clk;

  instr_seq_checker #(
    .DEPTH   (DEPTH),
    .GAP     (GAP),
    .RST_CYC (RST_CYC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_instr       (load_instr),
    .load_expect      (load_expect),
    .load_check       (load_check),
    .clear            (clear),
    .start            (start),
    .core_nrst        (core_nrst),
    .core_instr       (core_instr),
    .core_result      (core_result),
    .busy             (busy),
    .done             (done),
    .prog_len         (prog_len),
    .pass_cnt         (pass_cnt),
    .fail_cnt         (fail_cnt),
    .first_fail_valid (first_fail_valid),
    .first_fail_idx   (first_fail_idx)
  );

  // Tiny core model: I-type ALU ops with rs1=x0 write the sign-extended immediate.
  function automatic logic [31:0] core_model(input logic [31:0] ins);
    if (ins[6:0] == 7'h13) return {{20{ins[31]}}, ins[31:20]};
    return 32'h0;
  endfunction

  always_comb core_result = core_nrst ? core_model(core_instr) : 32'h0;

  function automatic vec_t mk(input logic [31:0] i0, input logic [31:0] e0, input logic c0,
                              input logic [31:0] i1, input logic [31:0] e1, input logic c1,
                              input logic [31:0] i2, input logic [31:0] e2, input logic c2,
                              input int p, input int f, input logic v, input int fi);
    vec_t r;
    r.instr[0] = i0; r.expv[0] = e0; r.chk[0] = c0;
    r.instr[1] = i1; r.expv[1] = e1; r.chk[1] = c1;
    r.instr[2] = i2; r.expv[2] = e2; r.chk[2] = c2;
    r.exp_pass = 8'(p);
    r.exp_fail = 8'(f);
    r.exp_ffv  = v;
    r.exp_ffi  = 8'(fi);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_entry(input logic [31:0] ins, input logic [31:0] ex, input logic c);
    load_valid  = 1'b1;
    load_instr  = ins;
    load_expect = ex;
    load_check  = c;
    @(posedge clk); #1;
    load_valid  = 1'b0;
    prog_q.push_back(ins);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    prog_q.delete();
  endtask

  // Expected core-side activity is queued at start and popped one entry per cycle.
  task automatic run_scoreboard(input string tag, input int restart_at);
    obs_t e;
    int   k;
    for (int c = 0; c < int'(RST_CYC); c++) sb.push_back({1'b0, RV_NOP});
    foreach (prog_q[i]) for (int s = 0; s < int'(SLOT); s++) sb.push_back({1'b1, prog_q[i]});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      start = (k == restart_at);
      @(negedge clk);
      chk({tag, ".nrst"},  64'(core_nrst),  64'(e.nrst));
      chk({tag, ".instr"}, 64'(core_instr), 64'(e.instr));
      chk({tag, ".busy"},  64'(busy),       64'(1));
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".done"},     64'(done),       64'(1));
    chk({tag, ".idle_nop"}, 64'(core_instr), 64'(RV_NOP));
    chk({tag, ".idle_rst"}, 64'(core_nrst),  64'(1));
  endtask

  task automatic chk_stats(input string tag, input int p, input int f, input logic v, input int fi);
    chk({tag, ".pass"}, 64'(pass_cnt),         64'(p));
    chk({tag, ".fail"}, 64'(fail_cnt),         64'(f));
    chk({tag, ".ffv"},  64'(first_fail_valid), 64'(v));
    chk({tag, ".ffi"},  64'(first_fail_idx),   64'(fi));
  endtask

  initial begin
    logic [31:0] w;
    vecs[0] = mk(32'h3e800093, 32'h000003E8, 1'b1, 32'h83000113, 32'hFFFFF830, 1'b1,
                 32'h3e906193, 32'h000003E9, 1'b1, 3, 0, 1'b0, 0);
    vecs[1] = mk(32'h3e800093, 32'h000003E8, 1'b1, 32'h83000113, 32'h00000000, 1'b1,
                 32'h3e906193, 32'h000003E9, 1'b1, 2, 1, 1'b1, 1);
    vecs[2] = mk(32'h3e800093, 32'h00000001, 1'b1, 32'h00111263, 32'hDEADBEEF, 1'b0,
                 32'h3e906193, 32'h00000000, 1'b1, 0, 2, 1'b1, 0);
    vecs[3] = mk(32'h00111263, 32'h12345678, 1'b0, 32'h83000113, 32'hFFFFF830, 1'b1,
                 32'h3e906193, 32'h000003E9, 1'b1, 2, 0, 1'b0, 0);

    rst = 1'b1; load_valid = 1'b0; load_instr = '0; load_expect = '0; load_check = 1'b0;
    clear = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 64'(busy), 64'(0));
    chk("reset.done", 64'(done), 64'(0));
    chk("reset.nrst", 64'(core_nrst), 64'(1));
    chk("reset.instr", 64'(core_instr), 64'(RV_NOP));
    chk("reset.len", 64'(prog_len), 64'(0));
    chk("reset.ready", 64'(load_ready), 64'(1));
    chk_stats("reset", 0, 0, 1'b0, 0);
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      pulse_clear();
      for (int j = 0; j < 3; j++) load_entry(vecs[v].instr[j], vecs[v].expv[j], vecs[v].chk[j]);
      @(negedge clk);
      chk($sformatf("vec%0d.len", v), 64'(prog_len), 64'(3));
      @(posedge clk); #1;
      run_scoreboard($sformatf("vec%0d", v), -1);
      chk_stats($sformatf("vec%0d", v), int'(vecs[v].exp_pass), int'(vecs[v].exp_fail),
                vecs[v].exp_ffv, int'(vecs[v].exp_ffi));
      @(posedge clk); #1;
    end

    // Fill to DEPTH, then offer one more entry.
    pulse_clear();
    for (int i = 0; i < int'(DEPTH); i++) begin
      w = {i[11:0], 20'h00093};
      load_entry(w, 32'(i), i[0]);
    end
    load_valid = 1'b1; load_instr = 32'hFFFFFFFF; load_expect = '0; load_check = 1'b1;
    @(negedge clk);
    chk("full.ready", 64'(load_ready), 64'(0));
    @(posedge clk); #1;
    load_valid = 1'b0;
    @(negedge clk);
    chk("full.len", 64'(prog_len), 64'(DEPTH));
    @(posedge clk); #1;
    run_scoreboard("full", -1);
    chk_stats("full", int'(DEPTH / 2), 0, 1'b0, 0);
    @(posedge clk); #1;

    // Empty program: only the core-reset window, then DONE.
    pulse_clear();
    run_scoreboard("empty", -1);
    chk_stats("empty", 0, 0, 1'b0, 0);
    @(posedge clk); #1;

    // start while busy is ignored; start from DONE reruns with fresh counters.
    pulse_clear();
    for (int j = 0; j < 3; j++) load_entry(vecs[1].instr[j], vecs[1].expv[j], vecs[1].chk[j]);
    run_scoreboard("busystart", 4);
    chk_stats("busystart", 2, 1, 1'b1, 1);
    @(posedge clk); #1;
    run_scoreboard("rerun", -1);
    chk_stats("rerun", 2, 1, 1'b1, 1);
    @(posedge clk); #1;

    // rst during slot 1 of a 3-entry run.
    pulse_clear();
    for (int j = 0; j < 3; j++) load_entry(vecs[0].instr[j], vecs[0].expv[j], vecs[0].chk[j]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (int'(RST_CYC + SLOT) + 1) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("midrst.slot1", 64'(core_instr), 64'(vecs[0].instr[1]));
    chk("midrst.pass_before", 64'(pass_cnt), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst.busy", 64'(busy), 64'(0));
    chk("midrst.done", 64'(done), 64'(0));
    chk("midrst.nrst", 64'(core_nrst), 64'(1));
    chk("midrst.instr", 64'(core_instr), 64'(RV_NOP));
    chk("midrst.len", 64'(prog_len), 64'(0));
    chk_stats("midrst", 0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
